// File: rtl/mdiv_pkg.sv
// Shared types and defaults for the multiply/divide datapath controllers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_SRA = 1'b0;
  localparam logic MODE_SLL = 1'b1;

  localparam int DEF_WIDTH    = 65;
  localparam int DEF_HI_WIDTH = 32;
  localparam int DEF_ITERS    = 32;

endpackage

// File: rtl/product_shift_reg_iter_counter.sv
// Iteration counter: clears on clr, steps on inc, flags the final iteration.
// Latency: count updates one edge after clr/inc; last is combinational from count.
// Backpressure: none; the caller holds inc low to freeze.
module iter_counter
  import mdiv_pkg::*;
#(
  parameter int ITERS = DEF_ITERS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         inc,
  output logic [$clog2(ITERS+1)-1:0]   count,
  output logic                         last
);

  localparam int CW = $clog2(ITERS + 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == CW'(ITERS - 1));

endmodule

// File: rtl/product_shift_reg.sv
// Product/remainder shift register with iteration control (PRODUCT_SHIFT_REG_ZERO_FLAG_EN adds a zero flag).
// Latency: done asserts ITERS unstalled RUN cycles after the start edge.
// Backpressure: stall freezes register and counter; out tristates when enable_out=0.
module product_shift_reg
  import mdiv_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HI_WIDTH = DEF_HI_WIDTH,
  parameter int ITERS    = DEF_ITERS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WIDTH-1:0]             in,
  input  logic                         mode,
  input  logic [HI_WIDTH-1:0]          hi_in,
  input  logic                         wr_hi,
  input  logic                         insert_bit,
  input  logic                         stall,
  input  logic                         enable_out,
  output logic [WIDTH-1:0]             out,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(ITERS+1)-1:0]   count
`ifdef PRODUCT_SHIFT_REG_ZERO_FLAG_EN
  ,
  output logic                         zero
`endif
);

  state_t             state;
  logic               mode_r;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   m;
  logic               load;
  logic               step;
  logic               last;

  // start is only honoured outside RUN, so a mid-operation start never reloads.
  assign load = start && (state != RUN);
  assign step = (state == RUN) && !stall;

  iter_counter #(
    .ITERS (ITERS)
  ) u_iter (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .inc   (step),
    .count (count),
    .last  (last)
  );

  always_comb begin
    m = q;
    if (wr_hi) begin
      m = {hi_in, q[WIDTH-HI_WIDTH-1:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q      <= '0;
      mode_r <= MODE_SRA;
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            q      <= in;
            mode_r <= mode;
            state  <= RUN;
            busy   <= 1'b1;
            done   <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (mode_r == MODE_SLL) begin
              q <= {m[WIDTH-2:0], insert_bit};
            end else begin
              q <= {m[WIDTH-1], m[WIDTH-1:1]};
            end
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign out = enable_out ? q : 'z;

`ifdef PRODUCT_SHIFT_REG_ZERO_FLAG_EN
  assign zero = (q == '0);
`endif

endmodule
